// File: rtl/conv_pkg.sv
// Shared sizes for the RGB 3x3 window path, plus the window packing helper.
// Packing: channel R/G/B high-to-low, k_0 (top-left) in the top byte of each channel.
package conv_pkg;
  localparam int PIX_W    = 8;
  localparam int CH       = 3;
  localparam int K        = 3;
  localparam int PIXEL_W  = 24;
  localparam int CH_WIN_W = 72;
  localparam int WIN_W    = 216;

  typedef logic [PIXEL_W-1:0] pixel_t;
  // Indexed [row][col]; row 0 is the oldest image row, col 0 the leftmost column.
  typedef logic [K-1:0][K-1:0][PIXEL_W-1:0] win_pix_t;

  function automatic logic [WIN_W-1:0] pack_window(input win_pix_t w);
    logic [WIN_W-1:0] o;
    o = '0;
    for (int ch = 0; ch < CH; ch++) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          o[ch*CH_WIN_W + (K*K-1-(r*K+c))*PIX_W +: PIX_W] = w[r][c][ch*PIX_W +: PIX_W];
        end
      end
    end
    return o;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// DEPTH-entry delay line: dout is the word written DEPTH enables ago.
// Read-before-write on one address per enable, so it maps onto a single-port RAM.
module line_buffer #(
  parameter int DEPTH = 416,
  parameter int W     = 24
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk_i) begin
    if (en) mem[ptr] <= din;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (en)  ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
  end
endmodule

// File: rtl/conv_window_gen.sv
// Raster RGB stream to 3x3x3 valid-convolution windows, one-cycle latency.
// Input is stalled whenever a held window is not taken downstream.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = 416,
  parameter int IMG_HEIGHT = 416
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               pix_valid_i,
  output logic               pix_ready_o,
  input  logic [PIXEL_W-1:0] pix_data_i,
  output logic               win_valid_o,
  input  logic               win_ready_i,
  output logic [WIN_W-1:0]   rgb_data_o,
  output logic               frame_done_o
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          produce;
  logic          row_end;
  logic          frame_end;
  pixel_t        lb0_dout;
  pixel_t        lb1_dout;
  win_pix_t      win_q;
  win_pix_t      win_nxt;

  assign pix_ready_o = !win_valid_o || win_ready_i;
  assign accept      = pix_valid_i && pix_ready_o;
  assign row_end     = (col == COL_LAST);
  assign frame_end   = row_end && (row == ROW_LAST);
  // Gating on col>=2 guarantees all three shifted columns belong to the current row.
  assign produce     = accept && (row >= RW'(2)) && (col >= CW'(2));

  line_buffer #(.DEPTH(IMG_WIDTH), .W(PIXEL_W)) u_lb0 (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .en    (accept),
    .din   (pix_data_i),
    .dout  (lb0_dout)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .W(PIXEL_W)) u_lb1 (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .en    (accept),
    .din   (lb0_dout),
    .dout  (lb1_dout)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (row_end) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_comb begin
    win_nxt = win_q;
    for (int r = 0; r < K; r++) begin
      win_nxt[r][0] = win_q[r][1];
      win_nxt[r][1] = win_q[r][2];
    end
    win_nxt[0][2] = lb1_dout;
    win_nxt[1][2] = lb0_dout;
    win_nxt[2][2] = pix_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      win_q        <= '0;
      win_valid_o  <= 1'b0;
      rgb_data_o   <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= accept && frame_end;
      if (accept) win_q <= win_nxt;
      if (produce) begin
        win_valid_o <= 1'b1;
        rgb_data_o  <= pack_window(win_nxt);
      end else if (win_ready_i) begin
        win_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// Randomised bench for conv_window_gen against a coordinate-based window model.
module tb_conv_window_gen;
  localparam int W = 5;
  localparam int H = 4;

  logic         clk_i = 1'b0;
  logic         rst_n;
  logic         pix_valid_i;
  logic         pix_ready_o;
  logic [23:0]  pix_data_i;
  logic         win_valid_o;
  logic         win_ready_i;
  logic [215:0] rgb_data_o;
  logic         frame_done_o;

  always #5 clk_i = ~clk_i;

  conv_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .pix_valid_i  (pix_valid_i),
    .pix_ready_o  (pix_ready_o),
    .pix_data_i   (pix_data_i),
    .win_valid_o  (win_valid_o),
    .win_ready_i  (win_ready_i),
    .rgb_data_o   (rgb_data_o),
    .frame_done_o (frame_done_o)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [23:0] pixval(input int r, input int c);
    logic [7:0] rv;
    rv = 8'(16 * r + c);
    return {rv, rv + 8'h40, rv + 8'h80};
  endfunction

  // Window centred so that (r,c) is bottom-right; bytes appended in row-major order.
  function automatic logic [215:0] expect_win(input int r, input int c);
    logic [71:0] rc, gc, bc;
    logic [23:0] p;
    rc = '0; gc = '0; bc = '0;
    for (int dr = -2; dr <= 0; dr++) begin
      for (int dc = -2; dc <= 0; dc++) begin
        p  = pixval(r + dr, c + dc);
        rc = {rc[63:0], p[23:16]};
        gc = {gc[63:0], p[15:8]};
        bc = {bc[63:0], p[7:0]};
      end
    end
    return {rc, gc, bc};
  endfunction

  task automatic chk(input string name, input logic [215:0] act, input logic [215:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Reference model state
  logic [215:0] q[$];
  logic [215:0] got[$];
  int           dut_fd[$];
  int           acc_cnt = 0;
  int           nr = 0;
  int           nc = 0;
  logic         exp_fd = 1'b0;
  logic         m_ev;

  always @(negedge clk_i) begin
    if (!rst_n) begin
      q.delete();
      nr = 0;
      nc = 0;
      exp_fd = 1'b0;
    end else begin
      m_ev = (q.size() != 0);
      chk1("win_valid", win_valid_o, m_ev);
      if (m_ev) chk("rgb_data", rgb_data_o, q[0]);
      chk1("frame_done", frame_done_o, exp_fd);
      chk1("pix_ready", pix_ready_o, !m_ev || win_ready_i);
      if (frame_done_o) dut_fd.push_back(acc_cnt);
      if (win_valid_o && win_ready_i) begin
        got.push_back(rgb_data_o);
        if (m_ev) void'(q.pop_front());
      end
      exp_fd = 1'b0;
      if (pix_valid_i && (!m_ev || win_ready_i)) begin
        acc_cnt++;
        if (nr >= 2 && nc >= 2) q.push_back(expect_win(nr, nc));
        if (nr == H - 1 && nc == W - 1) exp_fd = 1'b1;
        if (nc == W - 1) begin
          nc = 0;
          nr = (nr == H - 1) ? 0 : nr + 1;
        end else begin
          nc++;
        end
      end
    end
  end

  task automatic run(input int n, input int vp, input int rp);
    int tgt;
    int cyc;
    tgt = acc_cnt + n;
    cyc = 0;
    while (acc_cnt < tgt && cyc < 3000) begin
      pix_valid_i = ($urandom_range(99) < vp);
      win_ready_i = ($urandom_range(99) < rp);
      pix_data_i  = pixval(nr, nc);
      @(posedge clk_i); #1;
      cyc++;
    end
    pix_valid_i = 1'b0;
    chk1("run_budget", cyc < 3000, 1'b1);
  endtask

  task automatic drain();
    pix_valid_i = 1'b0;
    win_ready_i = 1'b1;
    repeat (4) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic pin_first_frame(input string tag, input int base);
    logic [215:0] w;
    chk({tag, "_count"}, 216'(got.size() - base), 216'(6));
    if (got.size() >= base + 6) begin
      w = got[base];
      chk({tag, "_w0_Rk0"}, 216'(w[215:208]), 216'(8'h00));
      chk({tag, "_w0_Rk8"}, 216'(w[151:144]), 216'(8'h22));
      chk({tag, "_w0_Gk0"}, 216'(w[143:136]), 216'(8'h40));
      chk({tag, "_w0_Bk8"}, 216'(w[7:0]),     216'(8'hA2));
      w = got[base + 3];
      chk({tag, "_w3_Rk0"}, 216'(w[215:208]), 216'(8'h10));
      w = got[base + 4];
      chk({tag, "_w4_Rk0"}, 216'(w[215:208]), 216'(8'h11));
    end
  endtask

  int a0, b0, c0, d0, e0, f0, s0;
  logic [215:0] snap;
  logic [215:0] wv;
  logic has0, has4;

  initial begin
    rst_n       = 1'b0;
    pix_valid_i = 1'b0;
    win_ready_i = 1'b0;
    pix_data_i  = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk1("rst_valid", win_valid_o, 1'b0);
    chk("rst_data", rgb_data_o, '0);
    chk1("rst_fd", frame_done_o, 1'b0);
    rst_n = 1'b1;
    @(posedge clk_i); #1;

    // Basic frame
    a0 = got.size();
    run(20, 100, 100);
    drain();
    pin_first_frame("basic", a0);

    // Backpressure on window 2
    b0 = got.size();
    run(15, 100, 100);
    snap = rgb_data_o;
    chk("bp_snap_Rk0", 216'(snap[215:208]), 216'(8'h02));
    win_ready_i = 1'b0;
    pix_valid_i = 1'b1;
    pix_data_i  = pixval(nr, nc);
    repeat (5) begin
      @(posedge clk_i); #1;
      chk1("bp_ready", pix_ready_o, 1'b0);
      chk("bp_hold", rgb_data_o, snap);
    end
    run(5, 100, 100);
    drain();
    chk("bp_count", 216'(got.size() - b0), 216'(6));
    for (int i = 0; i < 6 && b0 + i < got.size(); i++) chk("bp_win", got[b0 + i], got[a0 + i]);

    // Back-to-back frames
    c0 = got.size();
    f0 = dut_fd.size();
    s0 = acc_cnt;
    run(40, 100, 100);
    drain();
    chk("b2b_count", 216'(got.size() - c0), 216'(12));
    chk("b2b_fd_count", 216'(dut_fd.size() - f0), 216'(2));
    if (dut_fd.size() >= f0 + 2) begin
      chk("b2b_fd_pix1", 216'(dut_fd[f0] - s0), 216'(20));
      chk("b2b_fd_pix2", 216'(dut_fd[f0 + 1] - s0), 216'(40));
    end
    if (got.size() >= c0 + 7) chk("b2b_first_win", got[c0 + 6], got[c0]);

    // Reset mid-frame
    run(13, 100, 100);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_valid", win_valid_o, 1'b0);
    chk("mid_rst_data", rgb_data_o, '0);
    chk1("mid_rst_fd", frame_done_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    d0 = got.size();
    run(20, 100, 100);
    drain();
    pin_first_frame("restart", d0);

    // Random gaps over three frames
    e0 = got.size();
    run(60, 70, 60);
    drain();
    chk("rand_count", 216'(got.size() - e0), 216'(18));

    for (int i = 0; i < got.size(); i++) begin
      wv = got[i];
      has0 = 1'b0;
      has4 = 1'b0;
      for (int k = 0; k < 9; k++) begin
        if (wv[144 + 8*k +: 4] == 4'd0) has0 = 1'b1;
        if (wv[144 + 8*k +: 4] == 4'd4) has4 = 1'b1;
      end
      chk1("row_edge_mix", has0 && has4, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
